// File: rtl/commit_control_if.sv
// Head-of-ROB control bundle and commit-stage update/redirect outputs.
// slave = commit_control_unit, master = whatever presents the head entry.
interface commit_control_if #(
  parameter int WIDTH   = 31,
  parameter int CONTROL = 13,
  parameter int GHR_W   = 8
);
  logic               headReady;
  logic               headIsControl;
  logic [CONTROL:0]   controlFlow;
  logic [WIDTH:0]     targetAddress;
  logic [WIDTH:0]     seqPCC;
  logic [WIDTH:0]     regStatusC;

  logic               commitAck;
  logic               predWrite;
  logic [7:0]         predIndex;
  logic [1:0]         predState;
  logic               btbWrite;
  logic [WIDTH:0]     btbTarget;
  logic               flush;
  logic               redirectValid;
  logic [WIDTH:0]     redirectPC;
  logic [WIDTH:0]     regStatusRestore;
  logic [GHR_W-1:0]   ghr;
  logic [15:0]        mispredictCount;

  modport slave (
    input  headReady, headIsControl, controlFlow, targetAddress, seqPCC, regStatusC,
    output commitAck, predWrite, predIndex, predState, btbWrite, btbTarget,
           flush, redirectValid, redirectPC, regStatusRestore, ghr, mispredictCount
  );

  modport master (
    output headReady, headIsControl, controlFlow, targetAddress, seqPCC, regStatusC,
    input  commitAck, predWrite, predIndex, predState, btbWrite, btbTarget,
           flush, redirectValid, redirectPC, regStatusRestore, ghr, mispredictCount
  );
endinterface

// File: rtl/commit_control_unit.sv
// Commit-stage control-flow resolver: retires the ROB head, updates predictor/BTB/GHR,
// and raises a multi-cycle flush with redirect on mispredict or misdirect.
//
// state  | meaning
// IDLE   | watching the head entry; the only state in which head inputs are sampled
// RETIRE | one-cycle retire of a correctly resolved (or non-control) head
// FLUSH  | flush held for FLUSH_CYCLES cycles after a mispredict/misdirect retire
module commit_control_unit #(
  parameter int WIDTH        = 31,
  parameter int CONTROL      = 13,
  parameter int FLUSH_CYCLES = 2,
  parameter int GHR_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  commit_control_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RETIRE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t     state, state_nxt;
  logic [2:0] flush_cnt;

  logic [7:0] prev_index;
  logic [1:0] ctr_state;
  logic       write_btb, taken, mispredict, misdirect;
  logic       sample, take_flush;
  logic [1:0] ctr_next;

  assign prev_index = bus.controlFlow[CONTROL:CONTROL-7];
  assign ctr_state  = bus.controlFlow[5:4];
  assign write_btb  = bus.controlFlow[3];
  assign taken      = bus.controlFlow[2];
  assign mispredict = bus.controlFlow[1];
  assign misdirect  = bus.controlFlow[0];

  always_comb begin
    sample     = (state == IDLE) && bus.headReady;
    take_flush = sample && bus.headIsControl && (mispredict || misdirect);

    if (taken)
      ctr_next = (ctr_state == 2'd3) ? 2'd3 : ctr_state + 2'd1;
    else
      ctr_next = (ctr_state == 2'd0) ? 2'd0 : ctr_state - 2'd1;

    state_nxt = state;
    case (state)
      IDLE:    if (sample) state_nxt = take_flush ? FLUSH : RETIRE;
      RETIRE:  state_nxt = IDLE;
      FLUSH:   if (flush_cnt <= 3'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Every output is registered off the IDLE sample decision, so the strobes
  // land in the first RETIRE/FLUSH cycle together with commitAck.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.commitAck        <= 1'b0;
      bus.predWrite        <= 1'b0;
      bus.predIndex        <= '0;
      bus.predState        <= '0;
      bus.btbWrite         <= 1'b0;
      bus.btbTarget        <= '0;
      bus.flush            <= 1'b0;
      bus.redirectValid    <= 1'b0;
      bus.redirectPC       <= '0;
      bus.regStatusRestore <= '0;
      bus.ghr              <= '0;
      bus.mispredictCount  <= '0;
      flush_cnt            <= '0;
    end else begin
      bus.commitAck     <= sample;
      bus.redirectValid <= take_flush;
      bus.predWrite     <= sample && bus.headIsControl;
      bus.btbWrite      <= sample && write_btb;

      if (sample) begin
        bus.btbTarget <= bus.targetAddress;
        if (bus.headIsControl) begin
          bus.predIndex <= prev_index;
          bus.predState <= ctr_next;
          bus.ghr       <= {bus.ghr[GHR_W-2:0], taken};
        end
      end

      if (take_flush) begin
        bus.flush            <= 1'b1;
        flush_cnt            <= FLUSH_LOAD;
        bus.redirectPC       <= (misdirect || taken) ? bus.targetAddress : bus.seqPCC;
        bus.regStatusRestore <= bus.regStatusC;
        if (bus.mispredictCount != 16'hFFFF)
          bus.mispredictCount <= bus.mispredictCount + 16'd1;
      end else if (state == FLUSH) begin
        if (flush_cnt <= 3'd1) bus.flush <= 1'b0;
        else                   flush_cnt <= flush_cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_commit_control_unit.sv
// Randomized scoreboard bench for commit_control_unit: the driver pushes expected
// retire results, a negedge monitor pops and compares them when commitAck appears.
module tb_commit_control_unit;
  localparam int WIDTH        = 31;
  localparam int CONTROL      = 13;
  localparam int FLUSH_CYCLES = 2;
  localparam int GHR_W        = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  commit_control_if #(.WIDTH(WIDTH), .CONTROL(CONTROL), .GHR_W(GHR_W)) bus ();

  commit_control_unit #(
    .WIDTH(WIDTH), .CONTROL(CONTROL), .FLUSH_CYCLES(FLUSH_CYCLES), .GHR_W(GHR_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit          is_ctrl;
    bit          do_flush;
    logic [7:0]  idx;
    logic [1:0]  pst;
    logic        btbw;
    logic [31:0] btbt;
    logic [31:0] rpc;
    logic [31:0] rs;
    logic [7:0]  ghr;
    logic [15:0] mcnt;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int errors = 0;
  int checks = 0;

  // reference model state
  logic [7:0] ghr_m  = 8'h00;
  int         mcnt_m = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Drive a head entry and push its expected retire result; busy = edges the DUT ignores afterwards.
  task automatic present(input bit ctrl, input logic [7:0] idx, input logic [1:0] st,
                         input bit wbtb, input bit taken, input bit mp, input bit md,
                         input logic [31:0] tgt, input logic [31:0] seq, input logic [31:0] rs,
                         output int busy);
    exp_t e;
    int   ns;
    bus.headReady     = 1'b1;
    bus.headIsControl = ctrl;
    bus.controlFlow   = {idx, st, wbtb, taken, mp, md};
    bus.targetAddress = tgt;
    bus.seqPCC        = seq;
    bus.regStatusC    = rs;
    e.is_ctrl  = ctrl;
    e.do_flush = ctrl && (mp || md);
    e.idx      = idx;
    ns = int'(st) + (taken ? 1 : -1);
    if (ns > 3) ns = 3;
    if (ns < 0) ns = 0;
    e.pst = ns[1:0];
    if (ctrl) ghr_m = (ghr_m << 1) | {7'd0, taken};
    e.btbw = wbtb;
    e.btbt = tgt;
    e.rpc  = (md || taken) ? tgt : seq;
    e.rs   = rs;
    if (e.do_flush && mcnt_m < 65535) mcnt_m++;
    e.ghr  = ghr_m;
    e.mcnt = mcnt_m[15:0];
    sb.push_back(e);
    busy = e.do_flush ? FLUSH_CYCLES : 1;
  endtask

  task automatic issue(input bit ctrl, input logic [7:0] idx, input logic [1:0] st,
                       input bit wbtb, input bit taken, input bit mp, input bit md,
                       input logic [31:0] tgt, input logic [31:0] seq, input logic [31:0] rs);
    int busy;
    present(ctrl, idx, st, wbtb, taken, mp, md, tgt, seq, rs, busy);
    @(posedge clk);
    for (int b = 0; b < busy; b++) begin
      @(negedge clk);
      bus.headReady     = 1'($urandom_range(0, 1));
      bus.headIsControl = 1'($urandom_range(0, 1));
      bus.controlFlow   = 14'($urandom);
      bus.targetAddress = $urandom;
      bus.seqPCC        = $urandom;
      bus.regStatusC    = $urandom;
      @(posedge clk);
    end
    @(negedge clk);
    bus.headReady = 1'b0;
  endtask

  // monitor
  bit          fl_active = 0;
  int          fl_len    = 0;
  logic [31:0] fl_rs;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        fl_active = 0;
      end else if (bus.commitAck) begin
        if (sb.size() == 0) begin
          check("unexpected_commitAck", 1, 0);
        end else begin
          me = sb.pop_front();
          check("predWrite", bus.predWrite, me.is_ctrl);
          if (me.is_ctrl) begin
            check("predIndex", bus.predIndex, me.idx);
            check("predState", bus.predState, me.pst);
          end
          check("btbWrite", bus.btbWrite, me.btbw);
          check("btbTarget", bus.btbTarget, me.btbt);
          check("ghr", bus.ghr, me.ghr);
          check("mispredictCount", bus.mispredictCount, me.mcnt);
          check("flush_start", bus.flush, me.do_flush);
          check("redirectValid", bus.redirectValid, me.do_flush);
          if (me.do_flush) begin
            check("redirectPC", bus.redirectPC, me.rpc);
            check("regStatusRestore", bus.regStatusRestore, me.rs);
            fl_active = 1;
            fl_len    = 1;
            fl_rs     = me.rs;
          end
        end
      end else if (fl_active) begin
        check("redirectValid_single", bus.redirectValid, 0);
        if (bus.flush) begin
          fl_len++;
          check("regStatusRestore_hold", bus.regStatusRestore, fl_rs);
        end else begin
          check("flush_len", fl_len, FLUSH_CYCLES);
          fl_active = 0;
        end
      end else begin
        check("idle_flush", bus.flush, 0);
        check("idle_redirectValid", bus.redirectValid, 0);
        check("idle_predWrite", bus.predWrite, 0);
        check("idle_btbWrite", bus.btbWrite, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    int k;
    bit c, wb, tk, mp, md;
    bus.headReady     = 1'b0;
    bus.headIsControl = 1'b0;
    bus.controlFlow   = '0;
    bus.targetAddress = '0;
    bus.seqPCC        = '0;
    bus.regStatusC    = '0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_commitAck", bus.commitAck, 0);
    check("rst_flush", bus.flush, 0);
    check("rst_ghr", bus.ghr, 0);
    check("rst_mispredictCount", bus.mispredictCount, 0);
    check("rst_redirectPC", bus.redirectPC, 0);
    check("rst_regStatusRestore", bus.regStatusRestore, 0);
    check("rst_predIndex", bus.predIndex, 0);
    check("rst_btbTarget", bus.btbTarget, 0);
    reset = 1'b1;

    repeat (10) begin
      @(negedge clk);
      check("idle_commitAck", bus.commitAck, 0);
    end

    // directed cases
    issue(0, 8'h33, 2'd2, 0, 1, 1, 1, 32'h0000_5000, 32'h0000_0F04, 32'h1111_2222);
    issue(1, 8'h5A, 2'd3, 0, 1, 0, 0, 32'h0000_6000, 32'h0000_0F08, 32'h3333_4444);
    issue(1, 8'h21, 2'd2, 0, 0, 1, 0, 32'h0000_3000, 32'h0000_1004, 32'hDEAD_BEEF);
    issue(1, 8'h44, 2'd1, 1, 1, 0, 1, 32'h0000_2000, 32'h0000_1008, 32'hCAFE_F00D);
    issue(1, 8'h07, 2'd0, 0, 0, 0, 0, 32'h0000_7000, 32'h0000_100C, 32'h0);
    issue(1, 8'h08, 2'd1, 0, 1, 1, 0, 32'h0000_8000, 32'h0000_1010, 32'h5555_AAAA);

    // randomized traffic with idle gaps
    for (int i = 0; i < 250; i++) begin
      c  = 1'($urandom_range(0, 1));
      tk = 1'($urandom_range(0, 1));
      mp = ($urandom_range(0, 9) < 3);
      md = ($urandom_range(0, 9) < 2);
      wb = c ? 1'($urandom_range(0, 1)) : 1'b0;
      issue(c, 8'($urandom), 2'($urandom_range(0, 3)), wb, tk, mp, md,
            $urandom, $urandom, $urandom);
      k = $urandom_range(0, 2);
      repeat (k) @(negedge clk);
    end

    // reset asserted during the second flush cycle
    repeat (3) @(negedge clk);
    present(1, 8'h99, 2'd1, 1, 1, 1, 0, 32'h0000_4000, 32'h0000_1100, 32'h0BAD_CAFE, busy);
    @(posedge clk);
    @(negedge clk);
    bus.headReady = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rstflush_flush", bus.flush, 0);
    check("rstflush_ghr", bus.ghr, 0);
    check("rstflush_commitAck", bus.commitAck, 0);
    check("rstflush_redirectValid", bus.redirectValid, 0);
    check("rstflush_mispredictCount", bus.mispredictCount, 0);
    ghr_m  = 8'h00;
    mcnt_m = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post_reset_commitAck", bus.commitAck, 0);
      check("post_reset_flush", bus.flush, 0);
    end
    issue(1, 8'h3C, 2'd2, 0, 1, 0, 1, 32'h0000_9000, 32'h0000_1200, 32'h7777_8888);
    issue(1, 8'h3D, 2'd2, 0, 1, 0, 0, 32'h0000_A000, 32'h0000_1204, 32'h0);

    k = 0;
    while ((sb.size() != 0 || fl_active) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard_drain", sb.size(), 0);
    check("flush_tracker_idle", fl_active, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/commit_control_unit.md
# commit_control_unit

Commit-stage control-flow resolver downstream of the control buffer. Each cycle it examines the reorder-buffer head entry. For control-flow instructions it drives predictor and BTB update writes, maintains the committed global history register, and retires the entry. On a misprediction or misdirect it raises a multi-cycle pipeline flush with the redirect PC and register-status snapshot.

## Interface
- WIDTH, 31: MSB index of address, PC and register-status snapshot buses (width WIDTH+1).
- CONTROL, 13: MSB index of the control-flow bundle. Layout: [13:6] previousIndex, [5:4] state, [3] writeBTB, [2] takenBranch, [1] mispredict, [0] misdirect.
- FLUSH_CYCLES, 2: number of cycles flush is held asserted; legal range 1..7.
- GHR_W, 8: global history register width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- headReady  in  1  head ROB entry has written its result.
- headIsControl  in  1  head entry is a branch or jump.
- controlFlow  in  CONTROL+1  head control bundle.
- targetAddress  in  WIDTH+1  head resolved target.
- seqPCC  in  WIDTH+1  head sequential PC.
- regStatusC  in  WIDTH+1  head register-status snapshot.
- commitAck  out  1  retire head (advance read pointer); one-cycle pulse.
- predWrite  out  1  predictor counter write strobe.
- predIndex  out  8  predictor index (previousIndex).
- predState  out  2  updated saturating counter.
- btbWrite  out  1  BTB write strobe.
- btbTarget  out  WIDTH+1  BTB write data.
- flush  out  1  squash all younger instructions.
- redirectValid  out  1  one-cycle fetch redirect strobe.
- redirectPC  out  WIDTH+1  fetch restart address.
- regStatusRestore  out  WIDTH+1  snapshot for rename recovery; valid while flush=1.
- ghr  out  GHR_W  committed global history.
- mispredictCount  out  16  saturating misprediction counter.

## Operation
- FSM states: IDLE, RETIRE, FLUSH.
- IDLE:
  - headReady=0: hold all strobes low.
  - headReady=1, no mispredict or misdirect: go to RETIRE.
  - headReady=1, mispredict or misdirect (and headIsControl=1): go to FLUSH, load flush counter with FLUSH_CYCLES.
  - mispredict and misdirect are ignored when headIsControl=0.
- RETIRE (one cycle):
  - commitAck=1.
  - If headIsControl: predWrite=1; predIndex=previousIndex; predState=state+1 saturating at 3 when takenBranch=1, else state-1 saturating at 0; ghr <= {ghr[GHR_W-2:0], takenBranch}.
  - btbWrite=writeBTB, btbTarget=targetAddress.
  - Return to IDLE.
- FLUSH:
  - flush=1 for exactly FLUSH_CYCLES cycles.
  - First cycle: commitAck=1, redirectValid=1, predictor/BTB/ghr updates identical to RETIRE.
  - Redirect selection: misdirect, or mispredict with takenBranch=1 → redirectPC=targetAddress; mispredict with takenBranch=0 → seqPCC.
  - regStatusRestore is captured in the first cycle and held through FLUSH.
  - mispredictCount increments once per flush, saturating at 16'hFFFF.
  - Counter decrements each cycle; return to IDLE when it reaches 1.
- Head inputs are ignored outside IDLE. This guarantees one commitAck per entry while the head pointer settles.

## Timing
- All outputs are registered.
- Reset (reset=0, asynchronous): state=IDLE; every strobe, flush, commitAck=0; predIndex, predState, btbTarget, redirectPC, regStatusRestore, ghr=0; mispredictCount=0.
- Latency: head sampled ready at edge N → commitAck high during cycle N+1.
- Maximum throughput: one retire every 2 cycles (IDLE→RETIRE→IDLE). A mispredict retire occupies FLUSH_CYCLES+1 cycles including the IDLE sample cycle.
- Reset asserted mid-FLUSH: flush drops immediately (asynchronously), no further strobes are issued, and ghr clears.
- Counter saturation: state=3 taken → 3; state=0 not-taken → 0; mispredictCount=FFFF → holds.
- GHR wraps by shifting: the oldest bit is discarded.

## Test plan
- Reset, then headReady=0 for 10 cycles → all outputs 0 and state stays IDLE.
- Non-control head ready (headIsControl=0) → commitAck pulses one cycle after sampling; predWrite=0, btbWrite=0, ghr unchanged.
- Correctly predicted taken branch, previousIndex=8'h5A, state=2'b11 → predWrite=1, predIndex=5A, predState=3, ghr shifts in 1, flush never asserts.
- Mispredict not-taken, seqPCC=32'h0000_1004, FLUSH_CYCLES=2 → flush high exactly 2 cycles; redirectValid pulses once with redirectPC=1004; regStatusRestore equals regStatusC; predState=state-1; mispredictCount=1.
- Misdirect with targetAddress=32'h0000_2000, writeBTB=1 → btbWrite=1, btbTarget=2000, redirectPC=2000.
- reset pulled low during the second flush cycle → flush=0 immediately, ghr=0, no commitAck after reset is released until a new head is sampled ready.
